// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Branch resolution for the RISC core. Holds the {Z,O,C,S} flag register
//   (with same-cycle forwarding of incoming ALU flags), evaluates jump and
//   conditional-branch opcodes, computes the target PC and registers the
//   result with one cycle of latency. A PRED_DEPTH-entry table of 2-bit
//   saturating counters provides the direction prediction used by fetch;
//   resolved branches compare against the prediction carried with the
//   instruction to raise mispredict.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   fetch_pc / pred_taken       predictor lookup (combinational read)
//   valid_in, stall, flush      instruction qualifiers
//   opcode, FnCode              0110 jump, 0111 conditional branch
//   pc_in, offset_in, rs_value  operands for target / condition
//   pred_in                     prediction carried from fetch
//   flag_we, zflag..sflag       flag register write port
//   valid_out, branch, target,
//   mispredict                  registered resolution result
//   flags_q                     {z,o,c,s} flag register
module branch_resolve_unit #(
  parameter int DATA_W     = 32,
  parameter int OFFSET_W   = 16,
  parameter int PC_W       = 16,
  parameter int PRED_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     fetch_pc,
  output logic                pred_taken,
  input  logic                valid_in,
  input  logic                stall,
  input  logic                flush,
  input  logic [3:0]          opcode,
  input  logic [3:0]          FnCode,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [OFFSET_W-1:0] offset_in,
  input  logic [DATA_W-1:0]   rs_value,
  input  logic                pred_in,
  input  logic                flag_we,
  input  logic                zflag,
  input  logic                oflag,
  input  logic                cflag,
  input  logic                sflag,
  output logic                valid_out,
  output logic                branch,
  output logic [PC_W-1:0]     target,
  output logic                mispredict,
  output logic [3:0]          flags_q
);

  localparam int IDX_W = $clog2(PRED_DEPTH);
  localparam int EXT_W = (OFFSET_W > PC_W) ? OFFSET_W : PC_W;

  localparam logic [3:0] OP_JUMP  = 4'b0110;
  localparam logic [3:0] OP_BCOND = 4'b0111;

  // PC-relative target; the offset is sign-extended (or truncated) to the PC
  // width and the sum wraps silently modulo 2^PC_W.
  function automatic logic [PC_W-1:0] rel_target(
    input logic [PC_W-1:0]            pc,
    input logic signed [OFFSET_W-1:0] off
  );
    logic signed [EXT_W-1:0] off_ext;
    off_ext = EXT_W'(off);
    return pc + off_ext[PC_W-1:0];
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  // Conditional-branch predicate on the effective flags.
  function automatic logic cond_taken(
    input logic [3:0] fn,
    input logic       z,
    input logic       o,
    input logic       c,
    input logic       s,
    input logic       rs_zero
  );
    case (fn)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return c;
      4'b0011: return ~c;
      4'b0100: return s;
      4'b0101: return ~s;
      4'b0110: return o;
      4'b0111: return ~o;
      4'b1000: return rs_zero;
      4'b1001: return ~rs_zero;
      4'b1010: return s ^ o;
      default: return 1'b0;
    endcase
  endfunction

  logic [1:0] ctr [PRED_DEPTH];

  logic                     z_eff, o_eff, c_eff, s_eff;
  logic                     is_bcond_p0;
  logic                     taken_p0;
  logic [PC_W-1:0]          target_p0;
  logic                     train_p0;
  logic signed [OFFSET_W-1:0] offset_s;

  logic                     vld_p1;
  logic                     branch_p1;
  logic [PC_W-1:0]          target_p1;
  logic                     mispredict_p1;

  logic                     unused_fetch_bits;

  // ---- stage p0: decode, condition evaluation, target computation ----
  // Incoming flags are forwarded so a compare and its dependent branch can
  // issue back to back.
  assign z_eff = flag_we ? zflag : flags_q[3];
  assign o_eff = flag_we ? oflag : flags_q[2];
  assign c_eff = flag_we ? cflag : flags_q[1];
  assign s_eff = flag_we ? sflag : flags_q[0];

  assign offset_s = $signed(offset_in);

  always_comb begin
    is_bcond_p0 = 1'b0;
    taken_p0    = 1'b0;
    target_p0   = '0;
    case (opcode)
      OP_JUMP: begin
        case (FnCode)
          4'b0000: begin
            taken_p0  = 1'b1;
            target_p0 = rel_target(pc_in, offset_s);
          end
          4'b0001: begin
            taken_p0  = 1'b1;
            target_p0 = rs_value[PC_W-1:0];
          end
          default: begin
            taken_p0  = 1'b0;
            target_p0 = '0;
          end
        endcase
      end
      OP_BCOND: begin
        is_bcond_p0 = 1'b1;
        taken_p0    = cond_taken(FnCode, z_eff, o_eff, c_eff, s_eff, rs_value == '0);
        target_p0   = rel_target(pc_in, offset_s);
      end
      default: begin
        taken_p0  = 1'b0;
        target_p0 = '0;
      end
    endcase
  end

  // Only conditional branches that actually retire train the predictor.
  assign train_p0 = valid_in & ~flush & ~stall & is_bcond_p0;

  // Read happens from the registered table, so a same-cycle update of the
  // same entry is only visible from the following cycle.
  assign pred_taken = ctr[fetch_pc[IDX_W-1:0]][1];
  assign unused_fetch_bits = ^fetch_pc[PC_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PRED_DEPTH; i++) ctr[i] <= 2'b01;
    end else if (train_p0) begin
      ctr[pc_in[IDX_W-1:0]] <= sat_step(ctr[pc_in[IDX_W-1:0]], taken_p0);
    end
  end

  // The flag register follows flag_we regardless of the instruction stream.
  always_ff @(posedge clk) begin
    if (rst)          flags_q <= 4'b0000;
    else if (flag_we) flags_q <= {zflag, oflag, cflag, sflag};
  end

  // ---- stage p1: registered resolution result ----
  // flush takes priority over stall so a killed instruction never appears
  // as valid even while the outputs would otherwise be held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      branch_p1     <= 1'b0;
      target_p1     <= '0;
      mispredict_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1        <= 1'b0;
      branch_p1     <= 1'b0;
      target_p1     <= '0;
      mispredict_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1        <= valid_in;
      branch_p1     <= valid_in & taken_p0;
      target_p1     <= valid_in ? target_p0 : '0;
      mispredict_p1 <= valid_in & (taken_p0 != pred_in);
    end
  end

  assign valid_out  = vld_p1;
  assign branch     = branch_p1;
  assign target     = target_p1;
  assign mispredict = mispredict_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic        valid_in, stall, flush;
  logic [3:0]  opcode, FnCode;
  logic [15:0] pc_in;
  logic [15:0] offset_in;
  logic [31:0] rs_value;
  logic        pred_in;
  logic        flag_we, zflag, oflag, cflag, sflag;
  logic        valid_out, branch, mispredict;
  logic [15:0] target;
  logic [3:0]  flags_q;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  branch_resolve_unit #(
    .DATA_W(32), .OFFSET_W(16), .PC_W(16), .PRED_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .opcode(opcode), .FnCode(FnCode), .pc_in(pc_in), .offset_in(offset_in),
    .rs_value(rs_value), .pred_in(pred_in), .flag_we(flag_we),
    .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
    .valid_out(valid_out), .branch(branch), .target(target),
    .mispredict(mispredict), .flags_q(flags_q)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_ctr [16];
  int m_flags;
  bit m_vld, m_br, m_mis, m_care;
  int m_tgt;

  always @(posedge clk) begin
    bit fz, fo, fc, fs, tk, care;
    int tg, rel, idx;
    if (rst) begin
      m_vld = 0; m_br = 0; m_tgt = 0; m_mis = 0; m_care = 1; m_flags = 0;
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    end else begin
      fz = flag_we ? zflag : m_flags[3];
      fo = flag_we ? oflag : m_flags[2];
      fc = flag_we ? cflag : m_flags[1];
      fs = flag_we ? sflag : m_flags[0];
      rel = (int'(pc_in) + int'($signed(offset_in))) & 32'hFFFF;
      tk = 0; tg = 0; care = 1;
      if (opcode == 4'd6) begin
        if (FnCode == 0)      begin tk = 1; tg = rel; end
        else if (FnCode == 1) begin tk = 1; tg = int'(rs_value) & 32'hFFFF; end
        else care = 0;
      end else if (opcode == 4'd7) begin
        tg = rel;
        case (FnCode)
          0: tk = fz;   1: tk = !fz;  2: tk = fc;  3: tk = !fc;
          4: tk = fs;   5: tk = !fs;  6: tk = fo;  7: tk = !fo;
          8: tk = (rs_value == 0);    9: tk = (rs_value != 0);
          10: tk = (fs != fo);
          default: tk = 0;
        endcase
      end
      if (flush) begin
        m_vld = 0;
      end else if (!stall) begin
        m_vld  = valid_in;
        m_br   = valid_in && tk;
        m_tgt  = tg;
        m_care = care;
        m_mis  = valid_in && (tk != pred_in);
      end
      if (valid_in && !flush && !stall && opcode == 4'd7) begin
        idx = int'(pc_in) % 16;
        if (tk) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
      if (flag_we) m_flags = {28'd0, zflag, oflag, cflag, sflag};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid_out", 32'(valid_out), 32'(m_vld));
      check("m_mispredict", 32'(mispredict), m_vld ? 32'(m_mis) : 32'd0);
      if (m_vld) begin
        check("m_branch", 32'(branch), 32'(m_br));
        if (m_care) check("m_target", 32'(target), 32'(m_tgt));
      end
      check("m_flags_q", 32'(flags_q), 32'(m_flags));
      check("m_pred_taken", 32'(pred_taken), (m_ctr[int'(fetch_pc) % 16] >= 2) ? 32'd1 : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; stall = 0; flush = 0; opcode = 4'd0; FnCode = 4'd0;
    pc_in = 0; offset_in = 0; rs_value = 0; pred_in = 0;
    flag_we = 0; zflag = 0; oflag = 0; cflag = 0; sflag = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] fn,
                       input logic [15:0] pc, input logic [15:0] off,
                       input logic [31:0] rs, input logic pin);
    valid_in = 1; opcode = op; FnCode = fn; pc_in = pc;
    offset_in = off; rs_value = rs; pred_in = pin;
  endtask

  initial begin
    idle_inputs();
    rst = 1; fetch_pc = 16'd3;
    // 1: reset
    step(); step();
    rst = 0;
    #1;
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_target", 32'(target), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    chk_en = 1;

    // 2: unconditional relative jump
    issue(4'b0110, 4'b0000, 16'd10, 16'd4, 32'd0, 1'b0);
    step();
    check("jmp_branch", 32'(branch), 32'd1);
    check("jmp_target", 32'(target), 32'd14);
    check("jmp_mispredict", 32'(mispredict), 32'd1);

    // 3: flag forwarding into a BEQ-style branch
    issue(4'b0111, 4'b0000, 16'd20, 16'hFFFC, 32'd0, 1'b0);
    flag_we = 1; zflag = 1;
    step();
    flag_we = 0; zflag = 0;
    check("fwd_branch", 32'(branch), 32'd1);
    check("fwd_target", 32'(target), 32'd16);
    check("fwd_flags_q", 32'(flags_q), 32'b1000);

    // 4: training counter[5] with three taken carry branches
    fetch_pc = 16'd5;
    issue(4'b0111, 4'b0010, 16'd5, 16'd2, 32'd0, 1'b0);
    flag_we = 1; cflag = 1;
    #1;
    check("train_pre", 32'(pred_taken), 32'd0);
    step();
    flag_we = 0; cflag = 0;
    check("train_1", 32'(pred_taken), 32'd1);
    check("train_flags", 32'(flags_q), 32'b0010);
    step();
    check("train_2", 32'(pred_taken), 32'd1);
    step();
    check("train_3", 32'(pred_taken), 32'd1);
    check("train_branch", 32'(branch), 32'd1);
    check("train_target", 32'(target), 32'd7);

    // 5: signed-less-than with PC wrap
    issue(4'b0111, 4'b1010, 16'hFFFE, 16'd3, 32'd0, 1'b1);
    flag_we = 1; sflag = 1;
    step();
    flag_we = 0; sflag = 0;
    check("wrap_branch", 32'(branch), 32'd1);
    check("wrap_target", 32'(target), 32'h0001);
    check("wrap_mispredict", 32'(mispredict), 32'd0);

    // 6: non-branch, stall, flush-over-stall, reset while valid
    issue(4'b0000, 4'b0000, 16'd50, 16'd0, 32'd0, 1'b1);
    step();
    check("nb_valid", 32'(valid_out), 32'd1);
    check("nb_branch", 32'(branch), 32'd0);
    check("nb_target", 32'(target), 32'd0);
    check("nb_mispredict", 32'(mispredict), 32'd1);

    issue(4'b0110, 4'b0000, 16'd100, 16'd8, 32'd0, 1'b1);
    step();
    check("pre_stall_target", 32'(target), 32'd108);

    fetch_pc = 16'd7;
    issue(4'b0111, 4'b0011, 16'd7, 16'd1, 32'd0, 1'b0);
    stall = 1;
    step();
    check("stall_valid", 32'(valid_out), 32'd1);
    check("stall_target", 32'(target), 32'd108);
    check("stall_mispredict", 32'(mispredict), 32'd0);
    check("stall_no_train", 32'(pred_taken), 32'd0);

    flush = 1;
    step();
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_no_train", 32'(pred_taken), 32'd0);

    stall = 0; flush = 0;
    issue(4'b0110, 4'b0001, 16'd200, 16'd0, 32'hABCD1234, 1'b0);
    step();
    check("jr_valid", 32'(valid_out), 32'd1);
    check("jr_target", 32'(target), 32'h1234);

    rst = 1; fetch_pc = 16'd5;
    step();
    rst = 0;
    check("rst2_valid", 32'(valid_out), 32'd0);
    check("rst2_branch", 32'(branch), 32'd0);
    check("rst2_target", 32'(target), 32'd0);
    check("rst2_flags", 32'(flags_q), 32'd0);
    check("rst2_pred", 32'(pred_taken), 32'd0);

    // sweep of all sub-functions; the model checks every cycle
    for (int i = 0; i < 16; i++) begin
      logic [3:0] fl;
      fl = 4'((i * 5) % 16);
      issue((i % 5 == 4) ? 4'b0110 : 4'b0111, 4'(i), 16'(i * 1000),
            (i % 2 == 1) ? 16'(-(i * 7)) : 16'(i * 300),
            (i % 3 == 0) ? 32'd0 : 32'(i), 1'(i % 2));
      fetch_pc = 16'(i * 1000);
      flag_we = (i % 4 != 3);
      {zflag, oflag, cflag, sflag} = fl;
      step();
    end
    idle_inputs();

    // saturation at the bottom
    fetch_pc = 16'd9;
    for (int i = 0; i < 3; i++) begin
      issue(4'b0111, 4'b1111, 16'd9, 16'd0, 32'd0, 1'b1);
      step();
    end
    idle_inputs();
    check("sat_low", 32'(pred_taken), 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
